// File: rtl/pc_sequencer.sv
// Program sequencer for the picoMIPS core: owns the PC, resolves branches, stalls on switch input.
// Latency: PC advances one instruction per clock; an input instruction retires SYNC_STAGES+1 clocks after dataval falls.
// Backpressure: stall holds the PC and blocks register-file writes until a full dataval high/low handshake completes.
//
// Ports:
//   clk, nReset        rising-edge clock, asynchronous active-low reset
//   opcode, Wready     instruction class (00 ADD, 01 ADDI, 10 MULI, 11 B) and "consumes switch data" bit
//   dataval, sw_data   raw asynchronous SW8 valid switch and switch data
//   zflag, boffset     ALU zero flag and two's-complement branch offset
//   PCaddr             current program-memory address
//   data_in, INen      latched switch data and one-cycle register-file input select
//   stall              core stalled, register file must not write
module pc_sequencer #(
  parameter int Psize       = 6,
  parameter int datalength  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic [1:0]            opcode,
  input  logic                  Wready,
  input  logic                  dataval,
  input  logic [datalength-1:0] sw_data,
  input  logic                  zflag,
  input  logic [Psize-1:0]      boffset,
  output logic [Psize-1:0]      PCaddr,
  output logic [datalength-1:0] data_in,
  output logic                  INen,
  output logic                  stall
);

  localparam logic [1:0] OP_B = 2'b11;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_HI = 2'b01,
    WAIT_LO = 2'b10,
    RETIRE  = 2'b11
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [Psize-1:0]        pc_nxt;
  logic                    latch_en;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    dv_s;

  // dataval is a mechanical switch with no relation to clk; a plain shift
  // chain keeps metastability out of the FSM. SYNC_STAGES must be >= 2.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dataval};
    end
  end

  assign dv_s = sync_q[SYNC_STAGES-1];

  // State register, PC and switch-data latch.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state   <= RUN;
      PCaddr  <= '0;
      data_in <= '0;
    end else begin
      state  <= state_nxt;
      PCaddr <= pc_nxt;
      // sw_data is sampled raw: the operator holds the switches stable
      // across the whole handshake, so only dataval needs synchronising.
      if (latch_en) begin
        data_in <= sw_data;
      end
    end
  end

  // Next-state and next-PC logic. PC arithmetic wraps naturally at Psize
  // bits, which gives modulo-2^Psize behaviour in both branch directions.
  always_comb begin
    state_nxt = state;
    pc_nxt    = PCaddr;
    latch_en  = 1'b0;
    unique case (state)
      RUN: begin
        // Wready on a branch is meaningless; the branch always resolves.
        if (Wready && (opcode != OP_B)) begin
          state_nxt = WAIT_HI;
        end else if ((opcode == OP_B) && zflag) begin
          pc_nxt = PCaddr + boffset;
        end else begin
          pc_nxt = PCaddr + 1'b1;
        end
      end
      WAIT_HI: begin
        if (dv_s) begin
          latch_en  = 1'b1;
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // Requiring the falling edge stops a held switch from feeding
        // more than one input instruction.
        if (!dv_s) begin
          state_nxt = RETIRE;
        end
      end
      RETIRE: begin
        pc_nxt    = PCaddr + 1'b1;
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  // Outputs decoded purely from state: no path from dataval to any output.
  always_comb begin
    stall = 1'b0;
    INen  = 1'b0;
    unique case (state)
      WAIT_HI, WAIT_LO: stall = 1'b1;
      RETIRE:           INen  = 1'b1;
      default: begin
        stall = 1'b0;
        INen  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int Psize      = 6;
  localparam int datalength = 8;

  logic                  clk;
  logic                  nReset;
  logic [1:0]            opcode;
  logic                  Wready;
  logic                  dataval;
  logic [datalength-1:0] sw_data;
  logic                  zflag;
  logic [Psize-1:0]      boffset;
  logic [Psize-1:0]      PCaddr;
  logic [datalength-1:0] data_in;
  logic                  INen;
  logic                  stall;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .Psize(Psize),
    .datalength(datalength),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .opcode(opcode),
    .Wready(Wready),
    .dataval(dataval),
    .sw_data(sw_data),
    .zflag(zflag),
    .boffset(boffset),
    .PCaddr(PCaddr),
    .data_in(data_in),
    .INen(INen),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nReset  = 1'b0;
    opcode  = 2'b00;
    Wready  = 1'b0;
    dataval = 1'b0;
    sw_data = 8'h00;
    zflag   = 1'b0;
    boffset = 6'h00;

    // Reset held for three clocks.
    repeat (3) step();
    check("reset_pc", 32'(PCaddr), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_inen", 32'(INen), 32'd0);
    check("reset_data_in", 32'(data_in), 32'h00);

    // Release: ADD, one PC increment per clock.
    nReset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("inc_pc", 32'(PCaddr), 32'(i));
      check("inc_stall", 32'(stall), 32'd0);
      check("inc_inen", 32'(INen), 32'd0);
    end

    // PC=4: ADDI with Wready, switches show A5.
    opcode  = 2'b01;
    Wready  = 1'b1;
    sw_data = 8'hA5;
    step();
    check("hs_stall_entry", 32'(stall), 32'd1);
    check("hs_pc_held", 32'(PCaddr), 32'd4);

    // Raise dataval: two sync flops plus the latch edge.
    dataval = 1'b1;
    step();
    check("hs_no_early_latch", 32'(data_in), 32'h00);
    step();
    step();
    check("hs_data_latched", 32'(data_in), 32'hA5);
    check("hs_stall_wait_lo", 32'(stall), 32'd1);

    // Switch held high: nothing retires.
    repeat (10) step();
    check("hs_hold_pc", 32'(PCaddr), 32'd4);
    check("hs_hold_stall", 32'(stall), 32'd1);
    check("hs_hold_inen", 32'(INen), 32'd0);

    // Next instruction is a plain ADD; drop the switch.
    opcode  = 2'b00;
    Wready  = 1'b0;
    dataval = 1'b0;
    step();
    step();
    check("hs_fall_sync_stall", 32'(stall), 32'd1);
    check("hs_fall_sync_inen", 32'(INen), 32'd0);
    step();
    check("retire_inen", 32'(INen), 32'd1);
    check("retire_stall", 32'(stall), 32'd0);
    check("retire_pc", 32'(PCaddr), 32'd4);
    step();
    check("post_retire_inen", 32'(INen), 32'd0);
    check("post_retire_pc", 32'(PCaddr), 32'd5);

    // Run 5 -> 63, then wrap to 0.
    repeat (58) step();
    check("pre_wrap_pc", 32'(PCaddr), 32'd63);
    step();
    check("wrap_pc", 32'(PCaddr), 32'd0);

    // Branch at PC=10, offset -3, taken.
    repeat (10) step();
    check("pc_at_10", 32'(PCaddr), 32'd10);
    opcode  = 2'b11;
    boffset = 6'h3D;
    zflag   = 1'b1;
    step();
    check("branch_taken", 32'(PCaddr), 32'd7);

    // Back to PC=10, branch not taken.
    opcode = 2'b00;
    zflag  = 1'b0;
    repeat (3) step();
    check("pc_back_10", 32'(PCaddr), 32'd10);
    opcode = 2'b11;
    step();
    check("branch_not_taken", 32'(PCaddr), 32'd11);

    // Branch with Wready set must not stall.
    Wready = 1'b1;
    step();
    check("branch_wready_pc", 32'(PCaddr), 32'd12);
    check("branch_wready_stall", 32'(stall), 32'd0);
    Wready = 1'b0;

    // Run 12 -> 2 through the wrap, then branch backwards across zero.
    opcode = 2'b00;
    repeat (54) step();
    check("pc_at_2", 32'(PCaddr), 32'd2);
    opcode = 2'b11;
    zflag  = 1'b1;
    step();
    check("branch_wrap_back", 32'(PCaddr), 32'd63);

    // Halt idiom: branch to self.
    boffset = 6'h00;
    for (int i = 0; i < 20; i++) begin
      step();
      check("halt_pc", 32'(PCaddr), 32'd63);
      check("halt_stall", 32'(stall), 32'd0);
    end

    // 63 -> 0 -> 1, then start a handshake at PC=1.
    opcode = 2'b00;
    zflag  = 1'b0;
    step();
    step();
    check("pc_at_1", 32'(PCaddr), 32'd1);
    opcode  = 2'b10;
    Wready  = 1'b1;
    sw_data = 8'h3C;
    step();
    dataval = 1'b1;
    repeat (3) step();
    check("hs2_data_latched", 32'(data_in), 32'h3C);
    check("hs2_stall", 32'(stall), 32'd1);

    // Asynchronous reset in WAIT_LO, away from any clock edge.
    #2;
    nReset = 1'b0;
    #1;
    check("async_rst_pc", 32'(PCaddr), 32'd0);
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_data_in", 32'(data_in), 32'h00);
    check("async_rst_inen", 32'(INen), 32'd0);

    // Restart from PC 0 with a plain ADD.
    dataval = 1'b0;
    opcode  = 2'b00;
    Wready  = 1'b0;
    step();
    nReset = 1'b1;
    step();
    check("restart_pc", 32'(PCaddr), 32'd1);
    check("restart_stall", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program sequencer for the picoMIPS affine-transformation core.
- Owns the program counter (PC) and sequences instruction fetch.
- Resolves B (branch) instructions.
- Stalls the core on input instructions (Wready = I[6]) until the operator completes a full SW8 handshake: dataval raised, then lowered.
- Latches switch data and issues the INen pulse the register-file input mux uses. Sits between the program memory and the decoder/register file.

Parameters:
- Psize, 6, PC/program-address width (program memory depth 2^Psize).
- datalength, 8, width of switch input data.
- SYNC_STAGES, 2, synchroniser depth for the asynchronous dataval switch (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge.
- nReset  input  1  asynchronous active-low reset.
- opcode  input  2  instruction bits [Isize-1:Isize-2]: 00 ADD, 01 ADDI, 10 MULI, 11 B.
- Wready  input  1  instruction bit I[6]; 1 = instruction consumes switch data.
- dataval  input  1  raw SW8 data-valid switch, asynchronous.
- sw_data  input  datalength  raw switch data SW[7:0].
- zflag  input  1  ALU zero flag of the current cycle.
- boffset  input  Psize  two's-complement branch offset from the instruction immediate field.
- PCaddr  output  Psize  current program-memory address.
- data_in  output  datalength  latched switch data.
- INen  output  1  one-cycle strobe: select data_in as the register-file write source.
- stall  output  1  core stalled; the register file must not write.

Behaviour:
- Reset (async, nReset=0):
  - PCaddr=0, data_in=0, INen=0, stall=0.
  - Synchroniser flops cleared to 0.
  - State = RUN.
  - Reset asserted mid-handshake abandons the handshake; the core restarts at PC 0.
- Synchronisation:
  - dataval passes through SW8 synchronisation (SYNC_STAGES flops) to give dv_s.
  - A raw edge is visible in dv_s after SYNC_STAGES clocks.
  - sw_data is sampled only at the latch event, not synchronised further, because the operator holds the switches stable.
- FSM states: RUN, WAIT_HI, WAIT_LO, RETIRE.
- RUN (stall=0, INen=0):
  - If Wready=1 and opcode≠B: go to WAIT_HI, PC held.
  - Else if opcode=B and zflag=1: PC <= PC + boffset.
  - Else: PC <= PC + 1.
- WAIT_HI (stall=1, PC held):
  - When dv_s=1: data_in <= sw_data, go to WAIT_LO.
  - If dv_s is already 1 on entry, the latch happens on the first WAIT_HI cycle.
- WAIT_LO (stall=1, PC held):
  - When dv_s=0: go to RETIRE.
  - Holding the switch high never retires more than one instruction.
- RETIRE (stall=0, INen=1 for exactly this cycle):
  - PC <= PC + 1, then go to RUN.
  - The register file writes data_in this cycle.
- Arithmetic:
  - All PC arithmetic is modulo 2^Psize; wrap 63→0 on increment.
  - The branch target wraps in both directions, e.g. PC=2 with boffset=-3 (111101) gives 63.
- Wready on a B instruction is ignored; the branch is taken or not normally.
- Branch to self (boffset=0, zflag=1) holds PC indefinitely. This is the legal halt idiom; stall stays 0.
- No combinational path from dataval to any output. All outputs are registered or decoded from state.

Test Plan:
- Reset/increment: nReset low for 3 clocks, then release with opcode=00, Wready=0 → PCaddr 0,1,2,… one per clock; stall=0, INen=0.
- Wrap: run to PC=63 with ADD → next PCaddr=0.
- Input handshake (SYNC_STAGES=2):
  - At PC=4, ADDI with Wready=1 and sw_data=8'hA5 → stall=1 next cycle, PC stays 4.
  - Raise dataval → data_in=A5 two to three clocks later.
  - Hold dataval high 10 clocks → PC still 4.
  - Drop dataval → RETIRE: INen=1 for one clock, stall=0, then PCaddr=5.
- Branch, PC=10:
  - B with boffset=6'h3D (−3): zflag=1 → PCaddr=7; zflag=0 → PCaddr=11.
  - B at PC=2 with boffset −3 → 63.
  - B with Wready=1 → no stall.
- Halt idiom: B with boffset=0, zflag=1 → PCaddr constant for 20 clocks, stall=0.
- Reset mid-handshake: assert nReset in WAIT_LO → PCaddr=0, stall=0, data_in=0 immediately (asynchronous, no clock edge needed).
